// File: rtl/event_capture_fifo_pkg.sv
// Shared types and constants for the event capture FIFO.
// Widths of the stored entry and the legal FIFO depth range live here so the
// top, the storage sub-module and the interface agree on them.
package event_capture_pkg;

    localparam int unsigned ENTRY_W = 16;
    localparam int unsigned TS_W    = 8;
    localparam int unsigned CNT_W   = 8;

    // Legal range of DEPTH_LOG2 (FIFO depth 4..256 entries).
    localparam int unsigned DEPTH_LOG2_MIN = 2;
    localparam int unsigned DEPTH_LOG2_MAX = 8;

    // Width of the timestamp tick divider; covers TS_DIV up to 2**16.
    localparam int unsigned DIV_W = 16;

    // One captured sample; timestamp sits in the upper byte of the read word.
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    // Build an entry from a timestamp and a counter sample.
    function automatic entry_t pack_entry(input logic [TS_W-1:0] ts, input logic [CNT_W-1:0] cnt);
        entry_t e;
        e.ts  = ts;
        e.cnt = cnt;
        return e;
    endfunction

endpackage

// File: rtl/event_capture_fifo_if.sv
// Host/capture-side signal bundle for event_capture_fifo.
// master: the counter logic and host that drive capture and read requests.
// slave:  the FIFO itself.
interface event_capture_fifo_if
    import event_capture_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) ();

    logic                 clear;
    logic [CNT_W-1:0]     count_in;
    logic                 event_in;
    logic                 rd_en;
    logic [ENTRY_W-1:0]   rd_data;
    logic [DEPTH_LOG2:0]  level;
    logic                 empty;
    logic                 full;
    logic                 overflow;
    logic                 underflow;
    logic                 capture_pulse;

    modport master (
        output clear,
        output count_in,
        output event_in,
        output rd_en,
        input  rd_data,
        input  level,
        input  empty,
        input  full,
        input  overflow,
        input  underflow,
        input  capture_pulse
    );

    modport slave (
        input  clear,
        input  count_in,
        input  event_in,
        input  rd_en,
        output rd_data,
        output level,
        output empty,
        output full,
        output overflow,
        output underflow,
        output capture_pulse
    );

endinterface

// File: rtl/event_capture_fifo_mem.sv
// Storage for the event capture FIFO: a register array with one synchronous
// write port and one read port whose output register only updates on a read,
// so the last popped word is held between pops. No flow control lives here.
module capture_fifo_mem
    import event_capture_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  entry_t            wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output entry_t            rd_data_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    entry_t mem_q [Depth];
    entry_t mem_d [Depth];
    entry_t rd_data_q;
    entry_t rd_data_d;

    // Next array contents: only the addressed word changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            mem_d[wr_addr_i] = wr_data_i;
        end
    end

    // Array storage carries no reset; its contents are only visible through a pop.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read register loads the pre-write word, so a same-address write/read
    // returns the old (oldest) entry.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // Read output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/event_capture_fifo.sv
// Event capture FIFO: samples count_in on each rising edge of event_in, tags
// the sample with an 8-bit timestamp and queues it for 16-bit host readout.
// Status (level/empty/full and sticky overflow/underflow) is exported for
// wire-outs; capture_pulse is a one-cycle trigger per accepted capture.
// Build option EVENT_CAPTURE_OVERWRITE_EN: a capture into a full FIFO with no
// read replaces the oldest entry instead of being dropped.
module event_capture_fifo
    import event_capture_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned TS_DIV     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    event_capture_fifo_if.slave  bus
);

    localparam int unsigned    LvlW      = DEPTH_LOG2 + 1;
    localparam logic [LvlW-1:0] LevelMax = LvlW'(1 << DEPTH_LOG2);
    localparam logic [LvlW-1:0] LevelOne = LvlW'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);
    localparam logic [DIV_W-1:0] DivReload = DIV_W'(TS_DIV - 1);
    localparam logic [DIV_W-1:0] DivOne    = DIV_W'(1);
    localparam logic [TS_W-1:0]  TsOne     = TS_W'(1);

    logic [TS_W-1:0]       ts_q, ts_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  ev_q, ev_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  capture_pulse_q, capture_pulse_d;

    logic   rise;
    logic   is_empty;
    logic   is_full;
    logic   mem_we;
    logic   mem_re;
    logic   drop_oldest;
    entry_t wr_entry;
    entry_t rd_entry;

    assign rise     = bus.event_in & ~ev_q;
    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LevelMax);
    assign wr_entry = pack_entry(ts_q, bus.count_in);

    // Timestamp tick: divider counts down from TS_DIV-1; the timestamp steps
    // on the cycle the divider lands on zero (every cycle when TS_DIV is 1).
    always_comb begin
        ts_d  = ts_q;
        div_d = (div_q == '0) ? DivReload : (div_q - DivOne);
        if (div_d == '0) begin
            ts_d = ts_q + TsOne;
        end
        if (bus.clear) begin
            ts_d  = '0;
            div_d = DivReload;
        end
    end

    // FIFO control: flush wins, then pop/underflow, then push/overflow.
    always_comb begin
        ev_d            = bus.event_in;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        overflow_d      = overflow_q;
        underflow_d     = underflow_q;
        capture_pulse_d = 1'b0;
        mem_we          = 1'b0;
        mem_re          = 1'b0;
        drop_oldest     = 1'b0;

        if (bus.clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            // No bypass: a pop needs an entry that is already stored.
            if (bus.rd_en) begin
                if (is_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    mem_re = 1'b1;
                end
            end

            if (rise) begin
                if (!is_full || mem_re) begin
                    mem_we = 1'b1;
                end else begin
                    overflow_d = 1'b1;
`ifdef EVENT_CAPTURE_OVERWRITE_EN
                    // wr_ptr == rd_ptr when full, so this lands on the oldest entry.
                    mem_we      = 1'b1;
                    drop_oldest = 1'b1;
`endif
                end
            end

            if (mem_we) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (mem_re || drop_oldest) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end

            if (mem_we && !mem_re && !drop_oldest) begin
                level_d = level_q + LevelOne;
            end else if (mem_re && !mem_we) begin
                level_d = level_q - LevelOne;
            end

            capture_pulse_d = mem_we;
        end
    end

    // Control and status state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q            <= '0;
            div_q           <= '0;
            ev_q            <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
            capture_pulse_q <= 1'b0;
        end else begin
            ts_q            <= ts_d;
            div_q           <= div_d;
            ev_q            <= ev_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
            capture_pulse_q <= capture_pulse_d;
        end
    end

    capture_fifo_mem #(
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (mem_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_en_i   (mem_re),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    assign bus.rd_data       = rd_entry;
    assign bus.level         = level_q;
    assign bus.empty         = is_empty;
    assign bus.full          = is_full;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
    assign bus.capture_pulse = capture_pulse_q;

endmodule

// File: doc/event_capture_fifo.md
Name: event_capture_fifo

Overview:
- Sits downstream of the counter logic. Samples an 8-bit counter value on each rising edge of an event line (e.g. a counter-equals-00/80/FF pulse).
- Tags each sample with an 8-bit timestamp and buffers it in a small FIFO.
- Host readout is 16-bit words through a read strobe, compatible with a pipe-out endpoint; status goes to wire-outs and trigger-outs.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (legal 2..8).
- TS_DIV, 16, clock cycles per timestamp tick (legal 1..2**16).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous flush, active-high, one-cycle pulse or level.
- count_in  in  8  counter value to sample.
- event_in  in  1  event line; a capture occurs on its rising edge.
- rd_en  in  1  read strobe; pops one entry per asserted cycle.
- rd_data  out  16  {timestamp[7:0], count[7:0]} of the popped entry.
- level  out  DEPTH_LOG2+1  current entry count.
- empty  out  1  level == 0.
- full  out  1  level == 2**DEPTH_LOG2.
- overflow  out  1  sticky: a capture was lost (or overwrote data, see option).
- underflow  out  1  sticky: rd_en was asserted while empty.
- capture_pulse  out  1  one-cycle pulse per accepted capture.

Behaviour:
- Reset values: rd_data=0, level=0, empty=1, full=0, overflow=0, underflow=0, capture_pulse=0, timestamp=0, tick divider=0, event history register=0.
- Timestamp:
  - An 8-bit free-running counter increments once per TS_DIV clocks and wraps from 0xFF to 0x00.
  - The divider is a down-counter reloaded with TS_DIV-1; the timestamp increments on the cycle the divider reaches 0.
  - With TS_DIV=1 the timestamp increments every cycle.
- Edge detect:
  - event_in is registered once (ev_q). A rise is (event_in & ~ev_q), evaluated combinationally in cycle N.
  - On a rise in cycle N, count_in and the timestamp from cycle N are written at the posedge ending cycle N.
  - The entry is therefore visible (level incremented, capture_pulse=1) in cycle N+1.
  - event_in held high produces exactly one capture. It must return low for at least one cycle before the next capture.
- Read:
  - When rd_en=1 and not empty in cycle N, rd_data shows the oldest entry from cycle N+1 and holds until the next successful pop. The read pointer advances and level decrements.
  - When rd_en=1 while empty, rd_data is unchanged and underflow is set.
  - There is no bypass: a write and a read in the same cycle with level=0 is an underflow, and the write is still accepted.
- Simultaneous write and read, 0<level<max: level is unchanged and both pointers advance.
- Full:
  - A capture while full with no read in the same cycle is dropped. overflow is set and capture_pulse stays 0.
  - A capture while full with a read in the same cycle is accepted, and level stays at max.
- Pointers are DEPTH_LOG2 bits and wrap naturally. level is a separate DEPTH_LOG2+1 bit counter.
- clear takes priority over capture and read in the same cycle. It zeroes the pointers, level, overflow, underflow and timestamp, and reloads the divider. rd_data holds its value. The edge history is still updated.
- Reset asserted mid-operation aborts everything immediately, asynchronously, to the reset values.

Optional Feature:
- Macro: EVENT_CAPTURE_OVERWRITE_EN.
- Defined: a capture while full, with no read, overwrites the oldest entry. Both pointers advance, level stays at max, overflow is set, and capture_pulse=1.
- Undefined: the newest capture is dropped, as above.

Decomposition:
- Shared package event_capture_pkg holds:
  - ENTRY_W=16, TS_W=8, CNT_W=8.
  - An entry typedef {ts, cnt}.
  - Legal-range constants for DEPTH_LOG2.
- Sub-module capture_fifo_mem: a simple dual-port register array with a synchronous write and a registered read port. Control, level and flags stay in the top.

Test Plan:
- Reset, then a single capture: TS_DIV=4, count_in=0x5A, event rises at cycle 10. capture_pulse=1 and level=1 at cycle 11; after rd_en, rd_data=0x025A (timestamp 2), empty=1.
- Held event: event_in high for 20 cycles. Exactly one capture, level=1.
- Fill to full: DEPTH_LOG2=4, 17 captures. full=1 after 16, overflow=1. The 17th is dropped by default, or overwrites entry 0 with EVENT_CAPTURE_OVERWRITE_EN. Reads return the expected 16 entries in order.
- Full boundary: read and capture in the same cycle while full. level stays 16, overflow=0, and the new entry is last out.
- Underflow: rd_en while empty. underflow=1, rd_data unchanged. A subsequent clear gives underflow=0, level=0, timestamp=0.
- Async reset: reset asserted mid-stream with level=5. All outputs are 0 immediately (empty=1), and the next capture after release lands at read address 0.
